run_controller: RTL

- Run-control sequencer for the multi-cycle simple processor.
- Debounces the exec push button and drives the 3-bit phase sequence (idle, then P1..P5) that the control decoder and program counter consume.
- Arbitrates between start/stop requests from the user, the hlt decode, single-step mode and a PC breakpoint.
- Replaces the inline phase logic at the top level and adds a retired-instruction counter for the 7-seg/debug outputs.

---
 rtl/simple_pkg.sv | 28 ++
 rtl/run_controller_debouncer.sv | 41 ++++
 rtl/run_controller.sv | 98 +++++++++
 3 files changed

// File: rtl/simple_pkg.sv
// simple_pkg: shared phase and stop-reason encodings for the processor run-control path
//   phase_t       : 3-bit sequencer phase, PH_IDLE=0 then PH_1..PH_5 = 1..5
//   stop_reason_t : 2-bit cause of the last stop (step, user, hlt, breakpoint)
//   sr_rank()     : priority of a stop reason when several causes compete
package simple_pkg;

   typedef enum logic [2:0] {
      PH_IDLE = 3'd0,
      PH_1    = 3'd1,
      PH_2    = 3'd2,
      PH_3    = 3'd3,
      PH_4    = 3'd4,
      PH_5    = 3'd5
   } phase_t;

   typedef enum logic [1:0] {
      SR_STEP = 2'b00,
      SR_USER = 2'b01,
      SR_HLT  = 2'b10,
      SR_BP   = 2'b11
   } stop_reason_t;

   // hlt outranks breakpoint, which outranks user, which outranks step
   function automatic logic [1:0] sr_rank(input stop_reason_t r);
      return r == SR_HLT ? 2'd3 : r == SR_BP ? 2'd2 : r == SR_USER ? 2'd1 : 2'd0;
   endfunction

endpackage

// File: rtl/run_controller_debouncer.sv
// button_debouncer: synchronizes an active-low push button, debounces it and pulses on press
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   btn_n : raw active-low button, asynchronous to clk
//   press : one-cycle pulse when the debounced level goes from released to pressed
module button_debouncer #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          s1, s2, deb;
   logic [CW-1:0] cnt;
   logic          settle;

   // cnt holds how many consecutive samples so far differ from the debounced level;
   // the DEB_CYCLES-th differing sample commits the new level
   assign settle = (s2 != deb) && (cnt == CW'(DEB_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         deb   <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         s1    <= btn_n;
         s2    <= s1;
         cnt   <= (s2 == deb || settle) ? '0 : cnt + CW'(1);
         deb   <= settle ? s2 : deb;
         press <= settle && !s2;
      end
   end

endmodule

// File: rtl/run_controller.sv
// run_controller: run-control sequencer driving the P1..P5 phase sequence of the multi-cycle core
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   exec_n      : raw exec push button (active-low, asynchronous)
//   step_mode   : stop after every instruction
//   hlt         : halt decode from control, used during P1..P5
//   bp_en       : breakpoint enable
//   bp_addr     : breakpoint instruction address
//   pc          : current program counter
//   phase       : 0 idle, 1..5 = P1..P5
//   pc_e        : PC update enable, high exactly in P5
//   executing   : high while phase is not idle
//   halted      : sticky, last stop caused by hlt
//   stop_reason : 00 step, 01 user, 10 hlt, 11 breakpoint
//   instr_count : instructions retired since reset (wraps)
module run_controller
   import simple_pkg::*;
#(
   parameter int DEB_CYCLES = 16,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exec_n,
   input  logic             step_mode,
   input  logic             hlt,
   input  logic             bp_en,
   input  logic [15:0]      bp_addr,
   input  logic [15:0]      pc,
   output logic [2:0]       phase,
   output logic             pc_e,
   output logic             executing,
   output logic             halted,
   output logic [1:0]       stop_reason,
   output logic [CNT_W-1:0] instr_count
);

   phase_t       st, nxt;
   stop_reason_t sr, cause;
   logic         press, stop_pending, first_instr;
   logic         hit_bp, stop_now, take, leave;

   button_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn_n (exec_n),
      .press (press)
   );

   assign phase       = st;
   assign stop_reason = sr;

   // first_instr masks the breakpoint on the instruction a run starts from,
   // so resuming from a breakpoint does not stop again immediately
   assign hit_bp   = st == PH_1 && bp_en && pc == bp_addr && !first_instr;
   assign stop_now = st != PH_IDLE && (hlt || hit_bp || press);
   assign cause    = hlt ? SR_HLT : hit_bp ? SR_BP : SR_USER;
   // a later cause only overwrites the latched reason if it ranks higher
   assign take     = stop_now && (!stop_pending || sr_rank(cause) > sr_rank(sr));
   assign leave    = stop_pending || stop_now || step_mode;
   assign nxt      = st == PH_IDLE ? (press ? PH_1 : PH_IDLE)
                   : st == PH_5    ? (leave ? PH_IDLE : PH_1)
                   : phase_t'(st + 3'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st           <= PH_IDLE;
         pc_e         <= 1'b0;
         executing    <= 1'b0;
         halted       <= 1'b0;
         sr           <= SR_STEP;
         instr_count  <= '0;
         stop_pending <= 1'b0;
         first_instr  <= 1'b0;
      end else begin
         st        <= nxt;
         pc_e      <= nxt == PH_5;
         executing <= nxt != PH_IDLE;
         if (st == PH_IDLE) begin
            if (press) begin
               stop_pending <= 1'b0;
               halted       <= 1'b0;
               sr           <= SR_STEP;
               first_instr  <= 1'b1;
            end
         end else begin
            if (stop_now) stop_pending <= 1'b1;
            if (take) sr <= cause;
            if (hlt) halted <= 1'b1;
            if (st == PH_5) begin
               instr_count <= instr_count + CNT_W'(1);
               first_instr <= 1'b0;
            end
         end
      end
   end

endmodule
